// File: rtl/bru_pkg.sv
// bru_pkg: shared BrOp field constants, BHT counter encoding and the
// saturating counter helpers used by the branch resolve unit and its BHT.
package bru_pkg;

    // BrOp[4] marks an unconditional jump; BrOp[4:3] == 01 marks a conditional branch.
    localparam int         BR_JUMP_BIT   = 4;
    localparam logic [1:0] BR_CLASS_COND = 2'b01;

    // Condition select codes carried in BrOp[2:0] for conditional branches.
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Two-bit saturating predictor state; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    function automatic bht_state_t bht_inc(input bht_state_t s);
        return (s == ST) ? ST : bht_state_t'(s + 2'd1);
    endfunction

    function automatic bht_state_t bht_dec(input bht_state_t s);
        return (s == SNT) ? SNT : bht_state_t'(s - 2'd1);
    endfunction

endpackage

// File: rtl/bru_bht.sv
// bru_bht: branch history table of 2-bit saturating counters with one
// combinational read port for fetch and one train port for EX. A same-index
// read and write in one cycle returns the pre-update counter.
module bru_bht
    import bru_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_state_t bht_q [BHT_ENTRIES];
    bht_state_t bht_d [BHT_ENTRIES];
    logic [1:0] rd_state;

    // Read straight from the registered array so fetch never sees an in-flight update.
    always_comb begin
        rd_state = bht_q[rd_idx];
        rd_taken = rd_state[1];
    end

    // Step the addressed counter toward the resolved direction.
    always_comb begin
        bht_d = bht_q;
        if (wr_en) begin
            bht_d[wr_idx] = wr_taken ? bht_inc(bht_q[wr_idx]) : bht_dec(bht_q[wr_idx]);
        end
    end

    // Counter array; reset leaves every entry weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= WNT;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: resolves branches/jumps in EX, registers the outcome
// and misprediction flag, and trains a 2-bit BHT that fetch reads
// combinationally. Optional feature macro: BRU_PERF_EN adds saturating
// perf_branches / perf_mispredicts counters.
module branch_resolve_bht
    import bru_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            fetch_pred_taken,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] In1,
    input  logic [XLEN-1:0] In2,
    input  logic [4:0]      BrOp,
    input  logic            ex_pred_taken,
    output logic            NextPCSrc,
    output logic            res_valid,
    output logic            mispredict
`ifdef BRU_PERF_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic             is_jump;
    logic             is_cond;
    logic             cond_taken;
    logic             taken;
    logic             mispredict_now;
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             unused_pc_bits;

    logic res_valid_q,   res_valid_d;
    logic next_pc_src_q, next_pc_src_d;
    logic mispredict_q,  mispredict_d;

    assign fetch_idx      = fetch_pc[IDX_W+1:2];
    assign ex_idx         = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    // Operand comparator shared by every conditional branch flavour.
    always_comb begin
        eq   = (In1 == In2);
        lt_s = ($signed(In1) < $signed(In2));
        lt_u = (In1 < In2);
    end

    // Decode BrOp into branch class and the actual taken decision.
    always_comb begin
        is_jump    = BrOp[BR_JUMP_BIT];
        is_cond    = (BrOp[4:3] == BR_CLASS_COND);
        cond_taken = 1'b0;
        case (BrOp[2:0])
            BR_BEQ:  cond_taken = eq;
            BR_BNE:  cond_taken = !eq;
            BR_BLT:  cond_taken = lt_s;
            BR_BGE:  cond_taken = !lt_s;
            BR_BLTU: cond_taken = lt_u;
            BR_BGEU: cond_taken = !lt_u;
            default: cond_taken = 1'b0;
        endcase
        taken          = is_jump || (is_cond && cond_taken);
        mispredict_now = taken ^ ex_pred_taken;
    end

    // Next result values; a bubble clears all three so stale outcomes never linger.
    always_comb begin
        res_valid_d   = ex_valid;
        next_pc_src_d = ex_valid && taken;
        mispredict_d  = ex_valid && mispredict_now;
    end

    // Result registers giving the one-cycle resolve latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q   <= 1'b0;
            next_pc_src_q <= 1'b0;
            mispredict_q  <= 1'b0;
        end else begin
            res_valid_q   <= res_valid_d;
            next_pc_src_q <= next_pc_src_d;
            mispredict_q  <= mispredict_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign NextPCSrc  = next_pc_src_q;
    assign mispredict = mispredict_q;

    bru_bht #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (fetch_idx),
        .rd_taken (fetch_pred_taken),
        .wr_en    (ex_valid && is_cond),
        .wr_idx   (ex_idx),
        .wr_taken (cond_taken)
    );

`ifdef BRU_PERF_EN
    logic [31:0] perf_branches_q,    perf_branches_d;
    logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

    // Saturating event counters for resolved branches and mispredictions.
    always_comb begin
        perf_branches_d    = perf_branches_q;
        perf_mispredicts_d = perf_mispredicts_q;
        if (ex_valid && (is_jump || is_cond) && (perf_branches_q != 32'hFFFF_FFFF)) begin
            perf_branches_d = perf_branches_q + 32'd1;
        end
        if (ex_valid && mispredict_now && (perf_mispredicts_q != 32'hFFFF_FFFF)) begin
            perf_mispredicts_d = perf_mispredicts_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches_q    <= 32'd0;
            perf_mispredicts_q <= 32'd0;
        end else begin
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`else
    // Without the counters the unit is just the resolve path and the BHT.
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb_branch_resolve_bht: directed vectors with hand-computed expectations
// for the branch resolve unit and its BHT.
module tb_branch_resolve_bht;

    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BAD  = 5'b01010;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BGE  = 5'b01101;
    localparam logic [4:0] OP_BLTU = 5'b01110;
    localparam logic [4:0] OP_BGEU = 5'b01111;
    localparam logic [4:0] OP_JAL  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b00000;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        fetch_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  br_op;
    logic        ex_pred_taken;
    logic        next_pc_src;
    logic        res_valid;
    logic        mispredict;
`ifdef BRU_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    int vectors_applied = 0;
    int miscompares     = 0;

    branch_resolve_bht #(
        .XLEN        (32),
        .BHT_ENTRIES (64)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .In1              (in1),
        .In2              (in2),
        .BrOp             (br_op),
        .ex_pred_taken    (ex_pred_taken),
        .NextPCSrc        (next_pc_src),
        .res_valid        (res_valid),
        .mispredict       (mispredict)
`ifdef BRU_PERF_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one EX slot; inputs settle and are held across the next edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input logic pred);
        ex_valid      = v;
        ex_pc         = pc;
        br_op         = op;
        in1           = a;
        in2           = b;
        ex_pred_taken = pred;
        #1;
    endtask

    task automatic tickClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResult(input string tag, input logic v, input logic t, input logic m);
        checkOutput({tag, ".res_valid"},  {31'd0, res_valid},   {31'd0, v});
        checkOutput({tag, ".NextPCSrc"},  {31'd0, next_pc_src}, {31'd0, t});
        checkOutput({tag, ".mispredict"}, {31'd0, mispredict},  {31'd0, m});
    endtask

    task automatic checkPred(input string tag, input logic [31:0] pc, input logic exp);
        fetch_pc = pc;
        #1;
        checkOutput(tag, {31'd0, fetch_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b1;
        fetch_pc = 32'h0;
        applyStimulus(1'b0, 32'h0, OP_NOP, 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkResult("reset", 1'b0, 1'b0, 1'b0);
        checkPred("reset.pred0", 32'h0, 1'b0);
        checkPred("reset.pred4", 32'h4, 1'b0);
        checkPred("reset.predFC", 32'hFC, 1'b0);

        // BEQ taken at 0x40; fetch of the same index sees the old counter this cycle
        fetch_pc = 32'h40;
        applyStimulus(1'b1, 32'h40, OP_BEQ, 32'd5, 32'd5, 1'b0);
        checkOutput("beq.no_bypass", {31'd0, fetch_pred_taken}, 32'd0);
        tickClock();
        checkResult("beq", 1'b1, 1'b1, 1'b1);
        checkPred("beq.pred40", 32'h40, 1'b1);

        // Signed vs unsigned compares at 0x100 (entry 0)
        applyStimulus(1'b1, 32'h100, OP_BLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        tickClock();
        checkResult("blt", 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h100, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 1'b1);
        tickClock();
        checkResult("bltu", 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h100, OP_BGE, 32'd3, 32'd3, 1'b1);
        tickClock();
        checkResult("bge", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h100, OP_BGEU, 32'd0, 32'hFFFF_FFFF, 1'b0);
        tickClock();
        checkResult("bgeu", 1'b1, 1'b0, 1'b0);

        // BNE training at 0x80: three taken reach ST
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h80, OP_BNE, 32'd1, 32'd2, 1'b1);
            tickClock();
        end
        checkResult("bne.taken", 1'b1, 1'b1, 1'b0);
        checkPred("bne.st", 32'h80, 1'b1);
        applyStimulus(1'b1, 32'h80, OP_BNE, 32'd9, 32'd9, 1'b1);
        tickClock();
        checkResult("bne.nt", 1'b1, 1'b0, 1'b1);
        checkPred("bne.wt", 32'h80, 1'b1);
        applyStimulus(1'b1, 32'h80, OP_BNE, 32'd9, 32'd9, 1'b0);
        tickClock();
        checkPred("bne.wnt", 32'h80, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'h80, OP_BNE, 32'd9, 32'd9, 1'b0);
            tickClock();
        end
        applyStimulus(1'b1, 32'h80, OP_BNE, 32'd1, 32'd2, 1'b0);
        tickClock();
        checkPred("bne.snt_sat", 32'h80, 1'b0);
        applyStimulus(1'b1, 32'h80, OP_BNE, 32'd1, 32'd2, 1'b0);
        tickClock();
        checkPred("bne.back_wt", 32'h80, 1'b1);

        // Jumps and non-branches at 0xC0 leave the BHT untouched
        applyStimulus(1'b1, 32'hC0, OP_JAL, 32'd0, 32'd0, 1'b0);
        tickClock();
        checkResult("jal", 1'b1, 1'b1, 1'b1);
        checkPred("jal.pred", 32'hC0, 1'b0);
        applyStimulus(1'b1, 32'hC0, OP_NOP, 32'd4, 32'd4, 1'b1);
        tickClock();
        checkResult("nop.pred1", 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hC0, OP_NOP, 32'd4, 32'd4, 1'b0);
        tickClock();
        checkResult("nop.pred0", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'hC0, OP_BEQ, 32'd4, 32'd4, 1'b0);
        tickClock();
        checkResult("bubble", 1'b0, 1'b0, 1'b0);
        checkPred("bubble.pred", 32'hC0, 1'b0);
        applyStimulus(1'b1, 32'hC0, OP_BAD, 32'd4, 32'd4, 1'b1);
        tickClock();
        checkResult("badfunct", 1'b1, 1'b0, 1'b1);

        // Mid-stream reset after pushing entry 16 to ST
        applyStimulus(1'b1, 32'h40, OP_BEQ, 32'd7, 32'd7, 1'b0);
        tickClock();
        checkResult("prereset", 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        checkResult("midreset", 1'b0, 1'b0, 1'b0);
        checkPred("midreset.pred40", 32'h40, 1'b0);
        tickClock();
        checkResult("reset.held", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, OP_NOP, 32'd0, 32'd0, 1'b0);
        checkPred("postreset.pred40", 32'h40, 1'b0);
`ifdef BRU_PERF_EN
        checkOutput("perf_branches", perf_branches, 32'd0);
        checkOutput("perf_mispredicts", perf_mispredicts, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
